// File: rtl/ram_delay_tapper.sv
// ram_delay_tapper
// ----------------
// A circular sample buffer for the signal-generator datapath. One write stream
// stores din at wr_ptr on every sample strobe. NUM_TAPS independent read taps
// each return the sample written offset_k strobes earlier.
//
// Strobe/valid semantics: there is no back-pressure. A cycle with en=1 and
// clear=0 is one strobe, which performs one write and one read per tap. The
// tap results appear on dout/dout_valid at the clock edge that ends the strobe
// cycle, and they hold until the next strobe. dout_valid_k=1 means dout_k holds
// a sample that was written since the last reset/clear. dout_k is still
// updated when its valid is low, but its content is meaningless in that case.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   en         sample strobe
//   clear      synchronous flush of pointer, count and valids (wins over en)
//   din        sample written at wr_ptr on a strobe
//   offset     per-tap delay, tap k at [k*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   dout       per-tap delayed sample, tap k at [k*DATA_WIDTH +: DATA_WIDTH]
//   dout_valid per-tap valid flag
//   wr_ptr     next write address
//   filled     high once D samples have been written since reset/clear
//
// Parameters:
//   RW_MODE    1 = write-first: a tap with offset 0 returns din.
//              0 = read-first: a tap with offset 0 returns the old content of
//                  the cell, which is the sample from D strobes ago.
module ram_delay_tapper #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_TAPS      = 2,
  parameter int RW_MODE       = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              clear,
  input  logic [DATA_WIDTH-1:0]             din,
  input  logic [NUM_TAPS*ADDRESS_WIDTH-1:0] offset,
  output logic [NUM_TAPS*DATA_WIDTH-1:0]    dout,
  output logic [NUM_TAPS-1:0]               dout_valid,
  output logic [ADDRESS_WIDTH-1:0]          wr_ptr,
  output logic                              filled
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  // Sample storage. It is deliberately never reset: stale contents are masked
  // by the count gating on the valid flags instead.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Number of samples written before the current strobe, saturating at DEPTH.
  // Bit ADDRESS_WIDTH is set exactly when count == DEPTH.
  logic [ADDRESS_WIDTH:0] count;

  logic strobe;
  assign strobe = en & ~clear;

  // Per-tap read results, computed from the state at the start of the strobe.
  logic [ADDRESS_WIDTH-1:0] tap_off   [NUM_TAPS];
  logic [ADDRESS_WIDTH-1:0] tap_addr  [NUM_TAPS];
  logic [DATA_WIDTH-1:0]    tap_data  [NUM_TAPS];
  logic [NUM_TAPS-1:0]      tap_valid;

  always_comb begin
    tap_valid = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      tap_off[k]  = offset[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      // Natural modulo-D wrap from the ADDRESS_WIDTH-bit subtraction.
      tap_addr[k] = wr_ptr - tap_off[k];
      // Offset 0 addresses the cell being written in this strobe. In
      // write-first mode the tap forwards din. Otherwise the asynchronous read
      // returns the pre-write content.
      if ((RW_MODE != 0) && (tap_off[k] == '0)) begin
        tap_data[k] = din;
      end else begin
        tap_data[k] = mem[tap_addr[k]];
      end
      if (tap_off[k] == '0) begin
        // In read-first mode the old cell is only real data after a full lap.
        tap_valid[k] = (RW_MODE != 0) ? 1'b1 : count[ADDRESS_WIDTH];
      end else begin
        tap_valid[k] = (count >= {1'b0, tap_off[k]});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (strobe) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= '0;
    end else if (clear) begin
      // Valids drop but dout keeps its last value.
      wr_ptr     <= '0;
      count      <= '0;
      dout_valid <= '0;
    end else if (en) begin
      wr_ptr <= wr_ptr + ADDRESS_WIDTH'(1);
      if (!count[ADDRESS_WIDTH]) begin
        count <= count + (ADDRESS_WIDTH+1)'(1);
      end
      for (int k = 0; k < NUM_TAPS; k++) begin
        dout[k*DATA_WIDTH +: DATA_WIDTH] <= tap_data[k];
      end
      dout_valid <= tap_valid;
    end
  end

  assign filled = count[ADDRESS_WIDTH];

endmodule

// File: tb/tb_ram_delay_tapper.sv
// Testbench for ram_delay_tapper. Two instances with AW=4 (D=16) share the
// same stimulus: u_wf is write-first (RW_MODE=1) and u_rf is read-first
// (RW_MODE=0). Each scenario task drives directed vectors and compares the
// outputs against hand-computed values inline.
module tb_ram_delay_tapper;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NT = 2;

  logic           clk;
  logic           rst;
  logic           en;
  logic           clear;
  logic [DW-1:0]  din;
  logic [NT*AW-1:0] offset;

  logic [NT*DW-1:0] dout_wf, dout_rf;
  logic [NT-1:0]    dv_wf, dv_rf;
  logic [AW-1:0]    wp_wf, wp_rf;
  logic             filled_wf, filled_rf;

  int checks   = 0;
  int failures = 0;

  ram_delay_tapper #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_TAPS(NT), .RW_MODE(1)) u_wf (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .din(din), .offset(offset),
    .dout(dout_wf), .dout_valid(dv_wf), .wr_ptr(wp_wf), .filled(filled_wf)
  );

  ram_delay_tapper #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_TAPS(NT), .RW_MODE(0)) u_rf (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .din(din), .offset(offset),
    .dout(dout_rf), .dout_valid(dv_rf), .wr_ptr(wp_rf), .filled(filled_rf)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    clear  = 1'b0;
    din    = '0;
    offset = '0;
  end

  // Driver tasks. Inputs change 1 time unit after a rising edge, and outputs
  // are sampled at that same point, well away from the active edge.
  task automatic step(input logic e, input logic c, input logic [DW-1:0] d);
    en    = e;
    clear = c;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic set_offsets(input int o0, input int o1);
    offset = {AW'(o1), AW'(o0)};
  endtask

  task automatic reset_dut();
    en    = 1'b0;
    clear = 1'b0;
    rst   = 1'b0;
    #2;
    rst   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b0;
    #1;
    checks++; if (dout_wf !== '0)   begin failures++; $display("FAIL reset_dout_wf got=%h exp=0", dout_wf); end
    checks++; if (dv_wf !== '0)     begin failures++; $display("FAIL reset_valid_wf got=%b exp=0", dv_wf); end
    checks++; if (wp_wf !== '0)     begin failures++; $display("FAIL reset_wr_ptr_wf got=%0d exp=0", wp_wf); end
    checks++; if (filled_wf !== 1'b0) begin failures++; $display("FAIL reset_filled_wf got=%b exp=0", filled_wf); end
    checks++; if (dout_rf !== '0 || dv_rf !== '0 || wp_rf !== '0 || filled_rf !== 1'b0) begin
      failures++; $display("FAIL reset_rf dout=%h valid=%b wr_ptr=%0d filled=%b exp all 0", dout_rf, dv_rf, wp_rf, filled_rf);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Offsets {tap0=3, tap1=0}; din = i+1 on strobe i.
  task automatic test_basic_delay();
    reset_dut();
    set_offsets(3, 0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, DW'(i + 1));
      checks++; if (dv_wf[1] !== 1'b1 || dout_wf[15:8] !== DW'(i + 1)) begin
        failures++; $display("FAIL basic_tap1 strobe=%0d got=%0d/%b exp=%0d/1", i, dout_wf[15:8], dv_wf[1], i + 1);
      end
      checks++; if (dv_wf[0] !== (i >= 3)) begin
        failures++; $display("FAIL basic_tap0_valid strobe=%0d got=%b exp=%b", i, dv_wf[0], (i >= 3));
      end
      if (i >= 3) begin
        checks++; if (dout_wf[7:0] !== DW'(i - 2)) begin
          failures++; $display("FAIL basic_tap0_data strobe=%0d got=%0d exp=%0d", i, dout_wf[7:0], i - 2);
        end
      end
      checks++; if (wp_wf !== AW'((i + 1) % 16)) begin
        failures++; $display("FAIL basic_wr_ptr strobe=%0d got=%0d exp=%0d", i, wp_wf, (i + 1) % 16);
      end
    end
    en = 1'b0;
  endtask

  // Offset 15: the maximum delay, first valid after a full wrap.
  task automatic test_wrap();
    reset_dut();
    set_offsets(15, 0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, DW'(i + 1));
      checks++; if (dv_wf[0] !== (i >= 15)) begin
        failures++; $display("FAIL wrap_valid strobe=%0d got=%b exp=%b", i, dv_wf[0], (i >= 15));
      end
      if (i >= 15) begin
        checks++; if (dout_wf[7:0] !== DW'(i - 14)) begin
          failures++; $display("FAIL wrap_data strobe=%0d got=%0d exp=%0d", i, dout_wf[7:0], i - 14);
        end
      end
      checks++; if (wp_wf !== AW'((i + 1) % 16)) begin
        failures++; $display("FAIL wrap_wr_ptr strobe=%0d got=%0d exp=%0d", i, wp_wf, (i + 1) % 16);
      end
      checks++; if (filled_wf !== (i >= 15) || filled_rf !== (i >= 15)) begin
        failures++; $display("FAIL wrap_filled strobe=%0d got=%b/%b exp=%b", i, filled_wf, filled_rf, (i >= 15));
      end
    end
    en = 1'b0;
  endtask

  // Offset 0 on both instances: write-first forwards din, read-first
  // returns the sample from 16 strobes ago once a full lap exists.
  task automatic test_read_first();
    reset_dut();
    set_offsets(0, 0);
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 1'b0, DW'(i + 1));
      checks++; if (dv_rf[0] !== (i >= 16)) begin
        failures++; $display("FAIL rf_valid strobe=%0d got=%b exp=%b", i, dv_rf[0], (i >= 16));
      end
      if (i >= 16) begin
        checks++; if (dout_rf[7:0] !== DW'(i - 15)) begin
          failures++; $display("FAIL rf_data strobe=%0d got=%0d exp=%0d", i, dout_rf[7:0], i - 15);
        end
      end
      checks++; if (dv_wf[0] !== 1'b1 || dout_wf[7:0] !== DW'(i + 1)) begin
        failures++; $display("FAIL wf_collision strobe=%0d got=%0d/%b exp=%0d/1", i, dout_wf[7:0], dv_wf[0], i + 1);
      end
    end
    en = 1'b0;
  endtask

  // Strobes separated by idle cycles; outputs must hold through the gaps.
  task automatic test_gapped();
    reset_dut();
    set_offsets(1, 1);
    step(1'b1, 1'b0, 8'd10);
    checks++; if (dv_wf[0] !== 1'b0) begin failures++; $display("FAIL gap_s0_valid got=%b exp=0", dv_wf[0]); end
    step(1'b0, 1'b0, 8'd77);
    checks++; if (dv_wf[0] !== 1'b0 || wp_wf !== 4'd1) begin
      failures++; $display("FAIL gap_idle0 valid=%b wr_ptr=%0d exp 0/1", dv_wf[0], wp_wf);
    end
    step(1'b1, 1'b0, 8'd20);
    checks++; if (dv_wf[0] !== 1'b1 || dout_wf[7:0] !== 8'd10) begin
      failures++; $display("FAIL gap_s1 got=%0d/%b exp=10/1", dout_wf[7:0], dv_wf[0]);
    end
    step(1'b0, 1'b0, 8'd77);
    checks++; if (dv_wf[0] !== 1'b1 || dout_wf[7:0] !== 8'd10 || wp_wf !== 4'd2) begin
      failures++; $display("FAIL gap_idle1 got=%0d/%b wr_ptr=%0d exp=10/1/2", dout_wf[7:0], dv_wf[0], wp_wf);
    end
    step(1'b1, 1'b0, 8'd30);
    checks++; if (dv_wf[0] !== 1'b1 || dout_wf[7:0] !== 8'd20 || wp_wf !== 4'd3) begin
      failures++; $display("FAIL gap_s2 got=%0d/%b wr_ptr=%0d exp=20/1/3", dout_wf[7:0], dv_wf[0], wp_wf);
    end
    step(1'b0, 1'b0, 8'd77);
    checks++; if (dv_wf[0] !== 1'b1 || dout_wf[7:0] !== 8'd20 || wp_wf !== 4'd3) begin
      failures++; $display("FAIL gap_idle2 got=%0d/%b wr_ptr=%0d exp=20/1/3", dout_wf[7:0], dv_wf[0], wp_wf);
    end
  endtask

  // Clear with en=1 must flush state and suppress the write.
  task automatic test_clear();
    reset_dut();
    set_offsets(2, 6);
    // Prefill every cell with 100+addr.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(100 + i));
    step(1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, DW'(i + 1));
    // The last strobe was at p=9, so tap0 read address 7, which holds 8.
    checks++; if (dv_wf[0] !== 1'b1 || dout_wf[7:0] !== 8'd8) begin
      failures++; $display("FAIL clear_pre got=%0d/%b exp=8/1", dout_wf[7:0], dv_wf[0]);
    end
    step(1'b1, 1'b1, 8'd99);
    checks++; if (wp_wf !== 4'd0 || filled_wf !== 1'b0) begin
      failures++; $display("FAIL clear_state wr_ptr=%0d filled=%b exp 0/0", wp_wf, filled_wf);
    end
    checks++; if (dv_wf !== 2'b00 || dv_rf !== 2'b00) begin
      failures++; $display("FAIL clear_valid got=%b/%b exp=00/00", dv_wf, dv_rf);
    end
    checks++; if (dout_wf[7:0] !== 8'd8) begin
      failures++; $display("FAIL clear_dout_hold got=%0d exp=8", dout_wf[7:0]);
    end
    // The next strobe is at p=0. Tap1 (offset 6) reads cell 10, which must
    // still hold the prefill value 110. Both taps are invalid because count=0.
    step(1'b1, 1'b0, 8'd50);
    checks++; if (dv_wf !== 2'b00) begin
      failures++; $display("FAIL clear_post_valid got=%b exp=00", dv_wf);
    end
    checks++; if (dout_wf[15:8] !== 8'd110) begin
      failures++; $display("FAIL clear_no_write mem10=%0d exp=110", dout_wf[15:8]);
    end
    checks++; if (dout_wf[7:0] !== 8'd114) begin
      failures++; $display("FAIL clear_tap0_addr got=%0d exp=114", dout_wf[7:0]);
    end
    en = 1'b0;
  endtask

  // Reset dropped between edges must act immediately, and retained memory
  // must not be flagged valid afterwards.
  task automatic test_async_reset();
    reset_dut();
    set_offsets(5, 0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, DW'(i + 1));
    checks++; if (dv_wf[0] !== 1'b1 || dout_wf[7:0] !== 8'd15) begin
      failures++; $display("FAIL ar_pre got=%0d/%b exp=15/1", dout_wf[7:0], dv_wf[0]);
    end
    en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (dout_wf !== '0 || dv_wf !== '0 || wp_wf !== '0 || filled_wf !== 1'b0) begin
      failures++; $display("FAIL ar_immediate dout=%h valid=%b wr_ptr=%0d filled=%b exp all 0", dout_wf, dv_wf, wp_wf, filled_wf);
    end
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, DW'(200 + i));
      checks++; if (dv_wf[0] !== (i >= 5)) begin
        failures++; $display("FAIL ar_valid strobe=%0d got=%b exp=%b", i, dv_wf[0], (i >= 5));
      end
      if (i >= 5) begin
        checks++; if (dout_wf[7:0] !== DW'(195 + i)) begin
          failures++; $display("FAIL ar_data strobe=%0d got=%0d exp=%0d", i, dout_wf[7:0], 195 + i);
        end
      end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_delay();
    test_wrap();
    test_read_first();
    test_gapped();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
